// File: rtl/dnn_input_loader_if.sv
// dnn_input_loader_if: valid/ready word stream feeding the dnn input loader
interface dnn_input_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_wload;
  logic       s_ready;
  modport master (output s_valid, s_data, s_wload, input s_ready);
  modport slave  (input s_valid, s_data, s_wload, output s_ready);
endinterface

// File: rtl/dnn_input_loader.sv
// dnn_input_loader: assembles x/w frames from a word stream and presents them to the dnn with an in_ready level
module dnn_input_loader #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  dnn_input_loader_if.slave   s_if,
  output logic signed [6:0]   x0, x1, x2, x3,
  output logic signed [4:0]   w04, w05, w06, w07, w14, w15, w16, w17,
  output logic signed [4:0]   w24, w25, w26, w27, w34, w35, w36, w37,
  output logic signed [4:0]   w48, w49, w58, w59, w68, w69, w78, w79,
  output logic                in_ready,
  input  logic                dnn_done,
  output logic                busy,
  output logic                timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, FIRE, WAIT_DONE} state_t;
  state_t           state_q, state_d;
  logic [4:0]       word_cnt_q, word_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             wload_q, wload_d;
  logic             in_ready_q, in_ready_d;
  logic             err_q, err_d;
  logic [3:0][6:0]  x_q;
  logic [23:0][4:0] w_q;
  logic             accept;
  assign s_if.s_ready = (state_q == LOAD_X) || (state_q == LOAD_W);
  assign accept       = s_if.s_valid && s_if.s_ready;
  assign busy         = (state_q == FIRE) || (state_q == WAIT_DONE);
  assign in_ready     = in_ready_q;
  assign timeout_err  = err_q;
  assign {x3, x2, x1, x0} = x_q;
  assign {w79, w78, w69, w68, w59, w58, w49, w48,
          w37, w36, w35, w34, w27, w26, w25, w24,
          w17, w16, w15, w14, w07, w06, w05, w04} = w_q;
  // Control state, counters and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      wload_q    <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wload_q    <= wload_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end
  // Frame registers change only on an accepted word; word index selects the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      w_q <= '0;
    end else if (accept) begin
      if (word_cnt_q < 5'd4) x_q[word_cnt_q[1:0]] <= s_if.s_data[6:0];
      else w_q[word_cnt_q - 5'd4] <= s_if.s_data[4:0];
    end
  end
  // Next-state: load x, optionally load w, fire, then wait for done or timeout
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    wload_d    = wload_q;
    in_ready_d = in_ready_q;
    err_d      = err_q;
    case (state_q)
      IDLE: state_d = LOAD_X;
      LOAD_X: if (accept) begin
        word_cnt_d = word_cnt_q + 5'd1;
        if (word_cnt_q == 5'd0) begin
          wload_d = s_if.s_wload;
          err_d   = 1'b0;
        end
        if (word_cnt_q == 5'd3) state_d = wload_q ? LOAD_W : FIRE;
      end
      LOAD_W: if (accept) begin
        word_cnt_d = word_cnt_q + 5'd1;
        if (word_cnt_q == 5'd27) state_d = FIRE;
      end
      FIRE: begin
        in_ready_d = 1'b1;
        tmo_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (dnn_done) begin
          in_ready_d = 1'b0;
          state_d    = IDLE;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          in_ready_d = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dnn_input_loader.sv
// tb_dnn_input_loader: scoreboard bench for the dnn input loader
module tb_dnn_input_loader;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic dnn_done = 1'b0;
  always #5 clk = ~clk;
  dnn_input_loader_if s_if ();
  logic signed [6:0] x0, x1, x2, x3;
  logic signed [4:0] w04, w05, w06, w07, w14, w15, w16, w17;
  logic signed [4:0] w24, w25, w26, w27, w34, w35, w36, w37;
  logic signed [4:0] w48, w49, w58, w59, w68, w69, w78, w79;
  logic in_ready, busy, timeout_err;
  dnn_input_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(s_if),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w05(w05), .w06(w06), .w07(w07), .w14(w14), .w15(w15), .w16(w16), .w17(w17),
    .w24(w24), .w25(w25), .w26(w26), .w27(w27), .w34(w34), .w35(w35), .w36(w36), .w37(w37),
    .w48(w48), .w49(w49), .w58(w58), .w59(w59), .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready), .dnn_done(dnn_done), .busy(busy), .timeout_err(timeout_err)
  );
  typedef struct packed {
    logic [27:0]  x;
    logic [119:0] w;
  } frame_t;
  frame_t sb[$];
  frame_t last_e;
  logic [3:0][6:0]  mx = '0;
  logic [23:0][4:0] mw = '0;
  logic [7:0] fd [28];
  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int low_run = 0;
  int last_gap = 0;
  bit seen_high = 1'b0;
  wire [27:0]  dut_x = {x3, x2, x1, x0};
  wire [119:0] dut_w = {w79, w78, w69, w68, w59, w58, w49, w48, w37, w36, w35, w34,
                        w27, w26, w25, w24, w17, w16, w15, w14, w07, w06, w05, w04};
  always @(posedge clk) if (s_if.s_valid && s_if.s_ready) acc_cnt++;
  always @(negedge clk) begin
    if (!in_ready) low_run++;
    else begin
      if (low_run > 0 && seen_high) last_gap = low_run;
      seen_high = 1'b1;
      low_run = 0;
    end
  end
  task automatic push_word(input logic [7:0] d, input bit wl, input bit gaps);
    int g = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_if.s_valid = 1'b0;
      s_if.s_data  = 8'($urandom);
      s_if.s_wload = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_wload = wl;
    while (!s_if.s_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_word: s_ready stayed 0 for %0d cycles, required 1", g);
    end
    @(negedge clk);
  endtask
  task automatic send_frame(input bit wl, input bit gaps);
    int n = wl ? 28 : 4;
    for (int i = 0; i < n; i++) begin
      push_word(fd[i], (i == 0) ? wl : ~wl, gaps);
      if (i < 4) mx[i] = fd[i][6:0];
      else mw[i-4] = fd[i][4:0];
    end
    s_if.s_valid = 1'b0;
    sb.push_back({mx, mw});
  endtask
  task automatic check_frame(input string name);
    int g = 0;
    while (!in_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (!in_ready || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_rise: in_ready=%0b queued=%0d, required in_ready=1 with a queued frame", name, in_ready, sb.size());
    end else begin
      last_e = sb.pop_front();
      n_checks += 2;
      if (dut_x !== last_e.x) begin
        n_fail++;
        $display("FAIL %s_x: got %h, required %h", name, dut_x, last_e.x);
      end
      if (dut_w !== last_e.w) begin
        n_fail++;
        $display("FAIL %s_w: got %h, required %h", name, dut_w, last_e.w);
      end
    end
  endtask
  task automatic finish_frame(input string name);
    dnn_done = 1'b1;
    @(negedge clk);
    dnn_done = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: in_ready=%0b, required 0", name, in_ready);
    end
  endtask
  task automatic test_reset();
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    s_if.s_wload = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, s_if.s_ready, busy, timeout_err} !== 4'b0000 || dut_x !== '0 || dut_w !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags=%b x=%h w=%h, required all zero",
               {in_ready, s_if.s_ready, busy, timeout_err}, dut_x, dut_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (s_if.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: s_ready=%0b, required 0", s_if.s_ready);
    end
    @(negedge clk);
    n_checks++;
    if (s_if.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_loadx: s_ready=%0b, required 1", s_if.s_ready);
    end
  endtask
  task automatic test_full_frame();
    int a0 = acc_cnt;
    for (int i = 0; i < 4; i++) fd[i] = 8'(i + 1);
    for (int i = 4; i < 28; i++) fd[i] = 8'(i - 3);
    send_frame(1'b1, 1'b0);
    n_checks += 3;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fire: in_ready=%0b busy=%0b, required 0 1", in_ready, busy);
    end
    if (acc_cnt - a0 != 28) begin
      n_fail++;
      $display("FAIL full_accepts: got %0d, required 28", acc_cnt - a0);
    end
    @(negedge clk);
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency: in_ready=%0b one cycle after last accept, required 1", in_ready);
    end
    check_frame("full");
    n_checks++;
    if (w79 !== -5'sd8) begin
      n_fail++;
      $display("FAIL full_w79: got %0d, required -8", w79);
    end
  endtask
  task automatic test_done();
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1 || s_if.s_ready !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_flags: busy=%0b s_ready=%0b in_ready=%0b, required 1 0 1", busy, s_if.s_ready, in_ready);
    end
    if ({dut_x, dut_w} !== {last_e.x, last_e.w}) begin
      n_fail++;
      $display("FAIL wait_hold: got %h, required %h", {dut_x, dut_w}, {last_e.x, last_e.w});
    end
    finish_frame("done");
    n_checks += 2;
    if (busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_idle: busy=%0b s_ready=%0b, required 0 0", busy, s_if.s_ready);
    end
    @(negedge clk);
    if (s_if.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_rearm: s_ready=%0b, required 1", s_if.s_ready);
    end
  endtask
  task automatic test_xonly();
    int a0;
    dnn_done = 1'b1;
    @(negedge clk);
    dnn_done = 1'b0;
    n_checks++;
    if (s_if.s_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done: s_ready=%0b in_ready=%0b, required 1 0", s_if.s_ready, in_ready);
    end
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) fd[i] = 8'(i + 5);
    send_frame(1'b0, 1'b0);
    check_frame("xonly");
    #1;
    n_checks += 2;
    if (acc_cnt - a0 != 4) begin
      n_fail++;
      $display("FAIL xonly_accepts: got %0d, required 4", acc_cnt - a0);
    end
    if (last_gap < 6) begin
      n_fail++;
      $display("FAIL xonly_gap: in_ready low for %0d cycles, required at least 6", last_gap);
    end
    @(negedge clk);
    finish_frame("xonly");
  endtask
  task automatic test_sign();
    fd[0] = 8'h7F; fd[1] = 8'h80; fd[2] = 8'hC1; fd[3] = 8'h3F;
    fd[4] = 8'hF0;
    for (int i = 5; i < 28; i++) fd[i] = 8'($urandom);
    send_frame(1'b1, 1'b0);
    check_frame("sign");
    n_checks += 2;
    if (x0 !== -7'sd1 || x1 !== 7'sd0) begin
      n_fail++;
      $display("FAIL sign_x: x0=%0d x1=%0d, required -1 0", x0, x1);
    end
    if (w04 !== -5'sd16) begin
      n_fail++;
      $display("FAIL sign_w04: got %0d, required -16", w04);
    end
    finish_frame("sign");
  endtask
  task automatic test_timeout();
    int cnt = 0;
    for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
    send_frame(1'b0, 1'b0);
    check_frame("tmo");
    while (in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    n_checks += 3;
    if (cnt != TMO) begin
      n_fail++;
      $display("FAIL tmo_len: in_ready high %0d cycles, required %0d", cnt, TMO);
    end
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err: timeout_err=%0b busy=%0b, required 1 0", timeout_err, busy);
    end
    repeat (2) @(negedge clk);
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: timeout_err=%0b, required 1", timeout_err);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 28; i++) fd[i] = 8'($urandom);
    push_word(fd[0], 1'b1, 1'b0);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: timeout_err=%0b after word 0, required 0", timeout_err);
    end
    for (int i = 1; i <= 10; i++) push_word(fd[i], 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, s_if.s_ready, busy, timeout_err} !== 4'b0000 || dut_x !== '0 || dut_w !== '0) begin
      n_fail++;
      $display("FAIL midreset: flags=%b x=%h w=%h, required all zero",
               {in_ready, s_if.s_ready, busy, timeout_err}, dut_x, dut_w);
    end
    s_if.s_valid = 1'b0;
    mx = '0;
    mw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b0, 1'b1);
    check_frame("post_reset");
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || dut_x !== '0) begin
      n_fail++;
      $display("FAIL waitreset: in_ready=%0b x=%h, required 0 0", in_ready, dut_x);
    end
    mx = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) fd[i] = 8'($urandom);
    send_frame(1'b1, 1'b1);
    check_frame("gaps1");
    finish_frame("gaps1");
    send_frame(1'b1, 1'b1);
    check_frame("gaps2");
    finish_frame("gaps2");
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_done();
    test_xonly();
    test_sign();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
